// File: rtl/fp_add_ctrl_pkg.sv
// Shared types for the FP-adder sharing controller: FSM state encoding and operand width.
// Latency: n/a (type/constant package only).
// Backpressure: n/a.
package fp_add_ctrl_pkg;

    // IEEE-754 single precision operand/sum width.
    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester above last_grant_i, wrapping to the lowest index.
// Latency: purely combinational, zero cycles.
// Backpressure: enable_i low forces grant_o to zero; idx_o still reflects the would-be winner.
//
// Ports:
//   req_i        request vector, one bit per requester
//   last_grant_i index served most recently (its successor has top priority)
//   enable_i     arbiter may grant this cycle
//   grant_o      one-hot grant (zero when disabled or no request)
//   idx_o        binary index of the winner (0 when no request)
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    input  logic             enable_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pool;
    logic [NREQ-1:0] lowest;

    always_comb begin
        upper = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = (i > int'(last_grant_i));
        end
        // Requests strictly above the last winner take precedence; if none,
        // fall back to the full vector, which realises the wrap-around.
        masked = req_i & upper;
        pool   = (|masked) ? masked : req_i;
        // Two's-complement trick isolates the lowest set bit.
        lowest = pool & (~pool + NREQ'(1));

        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (lowest[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        grant_o = enable_i ? lowest : '0;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency FP adder among NREQ requesters, one operation in flight.
// Latency: grant cycle to rsp_valid is ADD_LAT+2 cycles; issue interval ADD_LAT+3 minimum.
// Backpressure: response held in RESP until rsp_ready; no grants while busy, requests wait.
//
// Ports:
//   clk18, rst18           clock and synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake, one-hot grant in IDLE only
//   req_a/req_b            packed operand pairs, requester i at [i*FP_W +: FP_W]
//   rsp_valid/rsp_ready    response handshake; rsp_sum/rsp_id held until accepted
//   busy                   high whenever an operation is being handled
//   fa_a/fa_b/fa_start     operands and one-cycle start pulse to the adder
//   fa_sum                 adder result, sampled exactly ADD_LAT cycles after start
module fp_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 4,
    parameter int FP_W    = fp_add_ctrl_pkg::FP_W
) (
    input  logic                     clk18,
    input  logic                     rst18,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP_W-1:0]     req_a,
    input  logic [NREQ*FP_W-1:0]     req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [FP_W-1:0]          rsp_sum,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy,
    output logic [FP_W-1:0]          fa_a,
    output logic [FP_W-1:0]          fa_b,
    output logic                     fa_start,
    input  logic [FP_W-1:0]          fa_sum
);
    import fp_add_ctrl_pkg::*;

    localparam int IDX_W = $clog2(NREQ);
    // Counter only needs to hold ADD_LAT-1; keep at least one bit for ADD_LAT=1.
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   rsp_id_q;
    logic [FP_W-1:0]    fa_a_q, fa_b_q, rsp_sum_q;
    logic [IDX_W-1:0]   win_idx;
    logic               arb_en;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (arb_en),
        .grant_o      (req_ready),
        .idx_o        (win_idx)
    );

    // State register and latency counter.
    always_ff @(posedge clk18) begin
        if (rst18) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ADD_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        arb_en    = (state_q == IDLE);
        fa_start  = (state_q == ISSUE);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    // Datapath: operands captured only in the grant cycle, sum only on the
    // final WAIT cycle, so both stay stable for the rest of the operation.
    always_ff @(posedge clk18) begin
        if (rst18) begin
            fa_a_q       <= '0;
            fa_b_q       <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
        end else begin
            if (state_q == IDLE && (|req_valid)) begin
                fa_a_q       <= req_a[int'(win_idx)*FP_W +: FP_W];
                fa_b_q       <= req_b[int'(win_idx)*FP_W +: FP_W];
                rsp_id_q     <= win_idx;
                last_grant_q <= win_idx;
            end
            if (state_q == WAIT && cnt_q == '0) begin
                rsp_sum_q <= fa_sum;
            end
        end
    end

    assign fa_a    = fa_a_q;
    assign fa_b    = fa_b_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_id  = rsp_id_q;

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one multi-cycle single-precision floating-point adder among NREQ requesters.
- Picks a requester by round-robin, latches its operand pair and pulses the adder start.
- Counts the adder's fixed latency, captures the sum, and returns it with the requester ID over a valid/ready response channel.
- Sits between client blocks and the sequential FP adder; one operation in flight at a time.

Parameters:
- NREQ, 4: number of requesters (2..8).
- ADD_LAT, 4: adder latency in clocks, measured from the fa_start cycle to a valid fa_sum (>=1).
- FP_W, 32: operand/sum width (IEEE-754 single).

Ports:
- clk18  in  1  clock, all logic on posedge.
- rst18  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept; high for one cycle when that requester's operands are taken.
- req_a  in  NREQ*FP_W  operand A, requester i at bits [i*FP_W +: FP_W].
- req_b  in  NREQ*FP_W  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_sum  out  FP_W  sum returned.
- rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_sum.
- busy  out  1  high in any state other than IDLE.
- fa_a  out  FP_W  operand A to the adder.
- fa_b  out  FP_W  operand B to the adder.
- fa_start  out  1  one-cycle start pulse to the adder.
- fa_sum  in  FP_W  adder result.

Behaviour:
- Reset (rst18=1 at posedge):
  - state=IDLE; req_ready=0, fa_start=0, rsp_valid=0, busy=0.
  - rsp_sum=0, rsp_id=0, fa_a=fa_b=0, cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - req_ready[winner] is driven combinationally in the same cycle.
  - At the posedge: req_a/req_b of the winner load into fa_a/fa_b, rsp_id<=winner, last_grant<=winner, state->ISSUE.
  - If no req_valid is high, the block stays in IDLE.
- ISSUE:
  - fa_start=1 for exactly this cycle; fa_a/fa_b are stable.
  - cnt<=ADD_LAT-1; state->WAIT.
- WAIT:
  - fa_start=0; fa_a/fa_b are held unchanged through the end of WAIT.
  - When cnt==0: rsp_sum<=fa_sum, rsp_valid<=1, state->RESP. Otherwise cnt decrements.
  - Sum capture happens exactly ADD_LAT clocks after the ISSUE posedge.
- RESP:
  - rsp_valid=1 and rsp_sum/rsp_id are held stable until rsp_ready=1.
  - On the handshake posedge: rsp_valid<=0, state->IDLE.
- Request/grant rules:
  - req_ready is 0 in every state except IDLE. Requests arriving in other states wait; they are never dropped by the arbiter.
  - A requester that deasserts req_valid before it is granted is not served and causes no error.
  - At most one req_ready bit is high in any cycle.
  - Operands are sampled only in the grant cycle, so the requester may change req_a/req_b afterward.
- Timing and fairness:
  - rsp_ready may already be high when rsp_valid rises; the handshake then completes in the first RESP cycle.
  - The next grant comes no earlier than the following IDLE cycle.
  - Minimum request-to-response latency is ADD_LAT+2 cycles (grant edge to rsp_valid). Minimum issue interval is ADD_LAT+3 cycles.
  - With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 other operations.
- Reset mid-operation: the in-flight operation is abandoned with no response, and the state goes to IDLE. An adder that is still running is ignored; the next ISSUE restarts it.
- No arithmetic is performed here. fa_sum is passed through bit-exact, including zero, overflow and underflow encodings.

Decomposition:
- Package fp_add_ctrl_pkg: state enum (IDLE, ISSUE, WAIT, RESP) and the FP_W constant.
- Sub-module rr_arbiter: inputs req vector, last_grant, enable; outputs one-hot grant and binary index. Purely combinational, parameterised by NREQ.
- The top holds the FSM, latency counter and datapath registers.

Test Plan:
- Single request: requester 0 sends a=0x3F800000 (1.0), b=0x40000000 (2.0) -> req_ready[0] for one cycle, fa_start once, then rsp_valid with rsp_sum=0x40400000 (3.0), rsp_id=0 exactly ADD_LAT+2 cycles after grant.
- All four requesters valid continuously, each with a distinct pair (requester i: a=1.0, b=i as float) -> grant order 0,1,2,3,0 and rsp_id sequence 0,1,2,3 with matching sums.
- Back-pressure: hold rsp_ready=0 for 10 cycles while requester 2 is valid -> rsp_valid, rsp_sum and rsp_id stay stable, req_ready stays 0, and there is no second fa_start until the handshake.
- Operand stability: change req_a on the cycle after grant -> fa_a keeps the granted value through all of WAIT; sum reflects the original operands.
- Assert rst18 in WAIT with ADD_LAT=4 -> next cycle busy=0, rsp_valid=0, no response for the abandoned op. The next request from requester 0 gets a correct result and grant priority restarts at requester 0.
- Requester 1 raises then drops req_valid while requester 3 is being served -> no grant to 1; the next grant goes to whichever requester is valid at IDLE.
